// File: rtl/wb_arb_rr.sv
// Round-robin arbiter: N cyc/ack masters onto one slave, one transfer in flight.
// Optional watchdog completes a hung slave transfer with an error pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transfer; arbitrate among s_cyc starting after last grant
// BUSY  | m_cyc high with latched master request; wait for m_ack or timeout
// ACK   | one-cycle s_ack/s_err/s_rdata pulse to the granted master
module wb_arb_rr #(
  parameter int N       = 2,
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*AW-1:0] s_addr,
  input  logic [N*DW-1:0] s_wdata,
  input  logic [N-1:0]    s_we,
  input  logic [N-1:0]    s_cyc,
  output logic [N-1:0]    s_ack,
  output logic [N-1:0]    s_err,
  output logic [N*DW-1:0] s_rdata,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic            m_we,
  output logic            m_cyc,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata,
  output logic [N-1:0]    m_gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Watchdog is a down-counter loaded at grant; terminal count 0 marks the
  // TIMEOUT-th m_cyc cycle.
  localparam logic [WW-1:0] WD_LOAD = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam logic [N-1:0]  GNT_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            m_we_q, m_we_d;
  logic            m_cyc_q, m_cyc_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [WW-1:0]   wdog_q, wdog_d;

  logic            hi_found, lo_found, any_req;
  logic [IW-1:0]   hi_idx, lo_idx, pick;
  logic            done;

  // Round-robin pick: first requester above the last grant, else lowest requester.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (s_cyc[i]) begin
        if (IW'(i) > rr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IW'(i);
        end
      end
    end
    pick    = hi_found ? hi_idx : lo_idx;
    any_req = hi_found | lo_found;
  end

  // Next-state and datapath updates for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_we_d    = m_we_q;
    m_cyc_d   = m_cyc_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_BUSY;
          rr_d      = pick;
          gnt_d     = GNT_ONE << pick;
          m_addr_d  = s_addr[int'(pick)*AW +: AW];
          m_wdata_d = s_wdata[int'(pick)*DW +: DW];
          m_we_d    = s_we[pick];
          m_cyc_d   = 1'b1;
          err_d     = 1'b0;
          wdog_d    = WD_LOAD;
        end
      end
      ST_BUSY: begin
        // A slave ack on the expiry cycle takes precedence over the timeout.
        if (m_ack) begin
          rdata_d = m_rdata;
          err_d   = 1'b0;
          done    = 1'b1;
        end else if (TIMEOUT > 0) begin
          if (wdog_q == '0) begin
            rdata_d = '0;
            err_d   = 1'b1;
            done    = 1'b1;
          end else begin
            wdog_d = wdog_q - 1'b1;
          end
        end
        if (done) begin
          state_d   = ST_ACK;
          m_cyc_d   = 1'b0;
          m_addr_d  = '0;
          m_wdata_d = '0;
          m_we_d    = 1'b0;
        end
      end
      // The acked master's s_cyc is still high here; it is only re-examined in IDLE.
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_q      <= IW'(N - 1);
      gnt_q     <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_we_q    <= 1'b0;
      m_cyc_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_we_q    <= m_we_d;
      m_cyc_q   <= m_cyc_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_we    = m_we_q;
  assign m_cyc   = m_cyc_q;
  assign m_gnt   = gnt_q;
  assign s_ack   = (state_q == ST_ACK) ? gnt_q : '0;
  assign s_err   = (state_q == ST_ACK && err_q) ? gnt_q : '0;

  // Read data is steered only to the acked master so per-master buses can be ORed.
  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (s_ack[i]) s_rdata[i*DW +: DW] = rdata_q;
    end
  end

endmodule
